// File: rtl/rr_arbiter_idx16.sv
// 16-requester round-robin arbiter producing a registered grant index and valid flag.
// Every grant change passes through at least one idle cycle, so decoded grant lines never overlap.
module rr_arbiter_idx16 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] req,
   output logic        gnt_valid,
   output logic [3:0]  gnt_idx,
   output logic        timeout_o
);

   // state | meaning
   // IDLE  | no live grant; requests sampled, gnt_idx holds last value
   // GRANT | gnt_idx owns the resource until release or hold timeout
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int unsigned CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);

   state_t        state_q, state_d;
   logic [3:0]    idx_q, idx_d;
   logic [3:0]    ptr_q, ptr_d;
   logic [CW-1:0] hold_q, hold_d;
   logic          timeout_q, timeout_d;

   logic [3:0]    cand;
   logic [3:0]    pick;
   logic          found;

   // First requester at or after ptr, wrapping 15 -> 0.
   always_comb begin
      cand  = ptr_q;
      pick  = ptr_q;
      found = 1'b0;
      for (int i = 0; i < 16; i++) begin
         cand = ptr_q + 4'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = GRANT;
               idx_d   = pick;
               ptr_d   = pick + 4'd1;
               hold_d  = CW'(1);
            end
         end
         GRANT: begin
            // Release takes precedence over a coincident timeout.
            if (!req[idx_q]) begin
               state_d = IDLE;
            end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LIM)) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
            end else if (hold_q != {CW{1'b1}}) begin
               hold_d = hold_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= 4'd0;
         ptr_q     <= 4'd0;
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt_valid = (state_q == GRANT);
   assign gnt_idx   = idx_q;
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_idx16.sv
// Bench for rr_arbiter_idx16: two instances (MAX_HOLD=4 and MAX_HOLD=0) checked every cycle
// against a behavioural model, plus directed literal expectations.
module tb_rr_arbiter_idx16;

   logic        clk;
   logic        rst;
   logic [15:0] req;

   logic        v4, t4, v0, t0;
   logic [3:0]  i4, i0;

   int checks   = 0;
   int failures = 0;
   bit model_on = 0;

   rr_arbiter_idx16 #(.MAX_HOLD(4)) dut4 (
      .clk(clk), .rst(rst), .req(req),
      .gnt_valid(v4), .gnt_idx(i4), .timeout_o(t4)
   );

   rr_arbiter_idx16 #(.MAX_HOLD(0)) dut0 (
      .clk(clk), .rst(rst), .req(req),
      .gnt_valid(v0), .gnt_idx(i0), .timeout_o(t0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model, index 0 -> MAX_HOLD=4 instance, index 1 -> MAX_HOLD=0 instance.
   int mh[2] = '{4, 0};
   bit mv[2];
   int mi[2];
   int mp[2];
   int mc[2];
   bit mt[2];

   always @(posedge clk) begin
      for (int n = 0; n < 2; n++) begin
         if (rst) begin
            mv[n] <= 0; mi[n] <= 0; mp[n] <= 0; mc[n] <= 0; mt[n] <= 0;
         end else if (!mv[n]) begin
            mt[n] <= 0;
            for (int k = 0; k < 16; k++) begin
               if (req[(mp[n] + k) % 16]) begin
                  mv[n] <= 1;
                  mi[n] <= (mp[n] + k) % 16;
                  mp[n] <= (mp[n] + k + 1) % 16;
                  mc[n] <= 1;
                  break;
               end
            end
         end else begin
            mt[n] <= 0;
            if (!req[mi[n]]) begin
               mv[n] <= 0;
            end else if (mh[n] != 0 && mc[n] == mh[n]) begin
               mv[n] <= 0;
               mt[n] <= 1;
            end else begin
               mc[n] <= mc[n] + 1;
            end
         end
      end
      if (rst) model_on <= 1;
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk("m4_valid",   int'(v4), int'(mv[0]));
         chk("m4_idx",     int'(i4), mi[0]);
         chk("m4_timeout", int'(t4), int'(mt[0]));
         chk("m0_valid",   int'(v0), int'(mv[1]));
         chk("m0_idx",     int'(i0), mi[1]);
         chk("m0_timeout", int'(t0), int'(mt[1]));
         chk("no_x", int'($isunknown({v4, i4, t4, v0, i0, t0})), 0);
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      req = 16'hFFFF;

      // reset held with all requests high
      for (int c = 0; c < 2; c++) begin
         step();
         chk("rst_valid",   int'(v4), 0);
         chk("rst_idx",     int'(i4), 0);
         chk("rst_timeout", int'(t4), 0);
      end
      rst = 1'b0;
      req = 16'h0000;
      step();

      // single requester 5, held four cycles then cleared (release beats timeout)
      req = 16'h0020;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("t2_valid", int'(v4), 1);
         chk("t2_idx",   int'(i4), 5);
      end
      req = 16'h0000;
      step();
      chk("t2_release",    int'(v4), 0);
      chk("t2_no_timeout", int'(t4), 0);

      // all requesting: 0..15,0 each 4 cycles then a timeout gap
      rst = 1'b1;
      req = 16'hFFFF;
      step();
      rst = 1'b0;
      for (int g = 0; g < 17; g++) begin
         for (int c = 0; c < 4; c++) begin
            step();
            chk("t3_valid",   int'(v4), 1);
            chk("t3_idx",     int'(i4), g % 16);
            chk("t3_to_low",  int'(t4), 0);
         end
         step();
         chk("t3_gap",     int'(v4), 0);
         chk("t3_to_high", int'(t4), 1);
      end

      // wrap: grant 14, release, then 0 and 14 request -> 0 wins
      req = 16'h4000;
      step();
      chk("t4_idx14", int'(i4), 14);
      req = 16'h0000;
      step();
      chk("t4_release", int'(v4), 0);
      req = 16'h4001;
      step();
      chk("t4_valid", int'(v4), 1);
      chk("t4_wrap",  int'(i4), 0);

      // reset in the middle of a grant to 9, then regrant
      req = 16'h0200;
      step();
      chk("t5_gap", int'(v4), 0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk("t5_valid", int'(v4), 1);
         chk("t5_idx",   int'(i4), 9);
      end
      rst = 1'b1;
      step();
      chk("t5_rst_valid", int'(v4), 0);
      chk("t5_rst_idx",   int'(i4), 0);
      rst = 1'b0;
      step();
      chk("t5_regrant_valid", int'(v4), 1);
      chk("t5_regrant_idx",   int'(i4), 9);

      // no timeout: requester 3 held 1000 cycles
      rst = 1'b1;
      step();
      rst = 1'b0;
      req = 16'h0008;
      for (int c = 0; c < 1000; c++) begin
         step();
         if (c == 0 || c == 999) begin
            chk("t6_valid", int'(v0), 1);
            chk("t6_idx",   int'(i0), 3);
         end
         if (t0 !== 1'b0) chk("t6_timeout", int'(t0), 0);
         if (v0 !== 1'b1) chk("t6_hold", int'(v0), 1);
      end
      req = 16'h0000;
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
